// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester block-RAM port arbiter.
//   arb_state_e : ownership state of the shared port
//   REQ0/REQ1   : requester index values used for the round-robin "last" owner
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // Ownership state corresponding to a requester index.
  function automatic arb_state_e own_state(input logic idx);
    return (idx == REQ1) ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick.
//   req0, req1   : requests
//   last         : index of the most recent owner (loses a tie)
//   pick_valid_c : at least one request present
//   pick_c       : chosen requester index
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic pick_valid_c,
  output logic pick_c
);

  always_comb begin
    pick_valid_c = req0 | req1;
    pick_c       = REQ0;
    if (req0 && req1) begin
      pick_c = ~last;
    end else if (req1) begin
      pick_c = REQ1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares port B of the instruction/data block RAM between r0 (RS232 loader/dumper)
// and r1 (CPU debug/monitor). One access per cycle, round-robin ownership with a
// bounded burst under contention, registered per-requester read-valid strobes.
//   clk, rst                    : clock, synchronous active-high reset
//   rN_req/we/addr/wdata        : requester N access request and payload
//   rN_gnt                      : access issued this cycle (combinational)
//   rN_rvalid                   : read data for requester N valid on rdata
//   rdata                       : shared read data (straight from mem_dout)
//   mem_we/mem_addr/mem_din     : RAM port B controls
//   mem_dout                    : RAM port B read data (1-cycle latency)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e       st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             last;
  logic             stay;
  logic             pick_valid;
  logic             pick;

  // While OWNk, last==k, so the same tie-break also yields the switch target.
  rr_pick2 u_pick (
    .req0         (r0_req),
    .req1         (r1_req),
    .last         (last),
    .pick_valid_c (pick_valid),
    .pick_c       (pick)
  );

  // Next ownership, burst count and port mux.
  always_comb begin
    st_nx  = ST_IDLE;
    cnt_nx = '0;
    stay   = 1'b0;

    case (st)
      ST_OWN0: stay = r0_req && ((cnt < CNT_W'(MAX_BURST)) || !r1_req);
      ST_OWN1: stay = r1_req && ((cnt < CNT_W'(MAX_BURST)) || !r0_req);
      default: stay = 1'b0;
    endcase

    if (rst) begin
      st_nx = ST_IDLE;
    end else if (stay) begin
      st_nx = st;
    end else if (pick_valid) begin
      st_nx = own_state(pick);
    end

    if (st_nx == ST_IDLE) begin
      cnt_nx = '0;
    end else if (st_nx != st) begin
      cnt_nx = CNT_W'(1);
    end else if (cnt < CNT_W'(MAX_BURST)) begin
      cnt_nx = cnt + CNT_W'(1);
    end else begin
      cnt_nx = cnt;
    end

    r0_gnt   = (st_nx == ST_OWN0);
    r1_gnt   = (st_nx == ST_OWN1);
    mem_we   = (r0_gnt & r0_we) | (r1_gnt & r1_we);
    mem_addr = r1_gnt ? r1_addr  : r0_addr;
    mem_din  = r1_gnt ? r1_wdata : r0_wdata;
  end

  // State, burst counter, last owner and read-valid pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      last      <= REQ1;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
    end else begin
      st        <= st_nx;
      cnt       <= cnt_nx;
      if (st_nx == ST_OWN0) last <= REQ0;
      if (st_nx == ST_OWN1) last <= REQ1;
      r0_rvalid <= r0_gnt & ~r0_we;
      r1_rvalid <= r1_gnt & ~r1_we;
    end
  end

  assign rdata = mem_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a write-first block RAM model
// (DEPTH=512) and a cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned DATA_W    = 32;
  localparam int          MAX_BURST = 4;
  localparam int unsigned DEPTH     = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              r0_req, r0_we, r1_req, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout)
  );

  // Block RAM port B, write-first.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[8:0]] <= mem_din;
      mem_dout           <= mem_din;
    end else begin
      mem_dout <= ram[mem_addr[8:0]];
    end
  end

  // Reference model: owner -1 = nobody, 0/1 = requester.
  int                m_owner = -1;
  int                m_cnt   = 0;
  int                m_last  = 1;
  bit                p0 = 1'b0, p1 = 1'b0;
  logic [DATA_W-1:0] pdata = '0;
  logic [DATA_W-1:0] shadow [DEPTH];
  int                g_last = -1;
  logic              obs_g0, obs_g1;

  int errors = 0;
  int checks = 0;

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h0001_0101;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_next();
    bit req [2];
    if (rst) return -1;
    req[0] = r0_req;
    req[1] = r1_req;
    if (m_owner >= 0 && req[m_owner] && (m_cnt < MAX_BURST || !req[1 - m_owner]))
      return m_owner;
    if (req[0] && req[1]) return 1 - m_last;
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  // One clock: check at negedge, advance model at posedge, return 1 time unit later.
  task automatic step();
    int   nx;
    logic we_exp;
    @(negedge clk);
    nx     = model_next();
    obs_g0 = r0_gnt;
    obs_g1 = r1_gnt;
    we_exp = (nx == 0) ? r0_we : (nx == 1) ? r1_we : 1'b0;
    chk("r0_gnt", 32'(r0_gnt), 32'(nx == 0));
    chk("r1_gnt", 32'(r1_gnt), 32'(nx == 1));
    chk("mem_we", 32'(mem_we), 32'(we_exp));
    if (nx >= 0) begin
      chk("mem_addr", 32'(mem_addr), 32'((nx == 0) ? r0_addr : r1_addr));
      if (we_exp) chk("mem_din", mem_din, (nx == 0) ? r0_wdata : r1_wdata);
    end
    chk("r0_rvalid", 32'(r0_rvalid), 32'(p0));
    chk("r1_rvalid", 32'(r1_rvalid), 32'(p1));
    if (p0 || p1) chk("rdata", rdata, pdata);
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = 1; p0 = 1'b0; p1 = 1'b0;
    end else begin
      p0 = (nx == 0) && !r0_we;
      p1 = (nx == 1) && !r1_we;
      if (p0) pdata = shadow[r0_addr[8:0]];
      if (p1) pdata = shadow[r1_addr[8:0]];
      if (nx == 0 && r0_we) shadow[r0_addr[8:0]] = r0_wdata;
      if (nx == 1 && r1_we) shadow[r1_addr[8:0]] = r1_wdata;
      if (nx < 0)             m_cnt = 0;
      else if (nx != m_owner) m_cnt = 1;
      else if (m_cnt < MAX_BURST) m_cnt = m_cnt + 1;
      m_owner = nx;
      if (nx >= 0) m_last = nx;
    end
    g_last = nx;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    @(posedge clk); #1;

    // Reset held with both requesting: nothing granted.
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("s1_first_gnt_r0", 32'(obs_g0), 32'd1);

    // r0 preloads addresses 0..15.
    r1_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r0_we = 1'b1; r0_addr = 10'(i); r0_wdata = init_val(i);
      step();
    end

    // r1 alone: 10 consecutive reads, no burst limit.
    r0_req = 1'b0; r0_we = 1'b0;
    r1_req = 1'b1; r1_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      r1_addr = 10'(i);
      step();
      chk("s4_gnt", 32'(obs_g1), 32'd1);
      chk("s4_rvalid", 32'(r1_rvalid), 32'd1);
      chk("s4_rdata", rdata, init_val(i));
    end

    // Write then read the same address.
    r1_req = 1'b0;
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 10'h005; r0_wdata = 32'hDEAD_BEEF;
    step();
    chk("s2_write_no_rvalid", 32'(r0_rvalid), 32'd0);
    r0_we = 1'b0;
    step();
    chk("s2_rvalid", 32'(r0_rvalid), 32'd1);
    chk("s2_rdata", rdata, 32'hDEAD_BEEF);
    chk("s2_r1_rvalid", 32'(r1_rvalid), 32'd0);

    // Continuous contention: bursts of 4 alternate, starting with r0.
    rst = 1'b1; step(); rst = 1'b0;
    r0_req = 1'b1; r1_req = 1'b1; r0_we = 1'b0; r1_we = 1'b0;
    for (int i = 0; i < 24; i++) begin
      r0_addr = 10'($urandom_range(15));
      r1_addr = 10'($urandom_range(15));
      step();
      chk("s3_g0", 32'(obs_g0), 32'(((i / 4) % 2) == 0));
      chk("s3_g1", 32'(obs_g1), 32'(((i / 4) % 2) == 1));
    end

    // Reset one cycle after a read grant drops the pending rvalid.
    rst = 1'b1; step(); rst = 1'b0;
    r1_req = 1'b0; r0_req = 1'b1; r0_addr = 10'h003;
    step(); step();
    rst = 1'b1;
    step();
    chk("s5_rvalid_cleared", 32'(r0_rvalid), 32'd0);
    rst = 1'b0; r1_req = 1'b1;
    step();
    chk("s5_restart_r0", 32'(obs_g0), 32'd1);

    // r0 drops after 2 grants; r1 takes over at once with a fresh burst.
    step();
    r0_req = 1'b0;
    step();
    chk("s6_handover", 32'(obs_g1), 32'd1);
    r0_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s6_burst_g1", 32'(obs_g1), 32'(i < 3));
      chk("s6_burst_g0", 32'(obs_g0), 32'(i == 3));
    end

    // Randomized traffic; a request is held until it is granted.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(63) == 0);
      if (!(r0_req && g_last != 0)) r0_req = ($urandom_range(3) != 0);
      if (!(r1_req && g_last != 1)) r1_req = ($urandom_range(3) != 0);
      r0_we = 1'($urandom_range(1)); r0_addr = 10'($urandom_range(15)); r0_wdata = $urandom;
      r1_we = 1'($urandom_range(1)); r1_addr = 10'($urandom_range(15)); r1_wdata = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
